// File: rtl/multicycle_control_if.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_control_if
//  Brief    : Control/datapath bundle between the multicycle MIPS control FSM
//             and the datapath it sequences.
//  Revision : 1.0 - initial release
// ============================================================================
interface multicycle_control_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic [1:0] ALUOp;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       IorD;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       RegDst;
    logic       MemtoReg;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] PCSource;
    logic       illegal_op;
    logic [3:0] state;

    modport master (
        input  opcode, mem_ready,
        output ALUOp, ALUSrcA, ALUSrcB, IorD, mem_read, mem_write, ir_write,
               reg_write, RegDst, MemtoReg, pc_write, pc_write_cond, PCSource,
               illegal_op, state
    );

    modport slave (
        output opcode, mem_ready,
        input  ALUOp, ALUSrcA, ALUSrcB, IorD, mem_read, mem_write, ir_write,
               reg_write, RegDst, MemtoReg, pc_write, pc_write_cond, PCSource,
               illegal_op, state
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_control
//  Brief    : Main control FSM of the multicycle MIPS datapath with memory
//             wait handshake and illegal-opcode flagging.
//  Revision : 1.0 - initial release
// ============================================================================
module multicycle_control #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_J     = 6'b000010
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_RCOMP   = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_ILLEGAL = 4'd10
    } state_t;

    state_t r_state;
    state_t w_next_state;
    logic   r_is_load;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_is_load <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_DECODE) begin
                r_is_load <= (bus.opcode == OP_LW);
            end
        end
    end

    // Outputs depend only on r_state and mem_ready; opcode feeds next-state only.
    always_comb begin
        w_next_state      = S_FETCH;
        bus.ALUOp         = 2'b00;
        bus.ALUSrcA       = 1'b0;
        bus.ALUSrcB       = 2'b00;
        bus.IorD          = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.reg_write     = 1'b0;
        bus.RegDst        = 1'b0;
        bus.MemtoReg      = 1'b0;
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.PCSource      = 2'b00;
        bus.illegal_op    = 1'b0;

        case (r_state)
            S_FETCH: begin
                w_next_state = bus.mem_ready ? S_DECODE : S_FETCH;
                bus.mem_read = 1'b1;
                bus.ALUSrcB  = 2'b01;
                bus.ir_write = bus.mem_ready;
                bus.pc_write = bus.mem_ready;
            end
            S_DECODE: begin
                if (bus.opcode == OP_LW || bus.opcode == OP_SW) w_next_state = S_MEMADR;
                else if (bus.opcode == OP_RTYPE)                w_next_state = S_EXEC;
                else if (bus.opcode == OP_BEQ)                  w_next_state = S_BRANCH;
                else if (bus.opcode == OP_J)                    w_next_state = S_JUMP;
                else                                            w_next_state = S_ILLEGAL;
                bus.ALUSrcB = 2'b11;
            end
            S_MEMADR: begin
                w_next_state = r_is_load ? S_MEMRD : S_MEMWR;
                bus.ALUSrcA  = 1'b1;
                bus.ALUSrcB  = 2'b10;
            end
            S_MEMRD: begin
                w_next_state = bus.mem_ready ? S_MEMWB : S_MEMRD;
                bus.mem_read = 1'b1;
                bus.IorD     = 1'b1;
            end
            S_MEMWB: begin
                bus.reg_write = 1'b1;
                bus.MemtoReg  = 1'b1;
            end
            S_MEMWR: begin
                w_next_state  = bus.mem_ready ? S_FETCH : S_MEMWR;
                bus.mem_write = 1'b1;
                bus.IorD      = 1'b1;
            end
            S_EXEC: begin
                w_next_state = S_RCOMP;
                bus.ALUSrcA  = 1'b1;
                bus.ALUOp    = 2'b10;
            end
            S_RCOMP: begin
                bus.reg_write = 1'b1;
                bus.RegDst    = 1'b1;
            end
            S_BRANCH: begin
                bus.ALUSrcA       = 1'b1;
                bus.ALUOp         = 2'b01;
                bus.pc_write_cond = 1'b1;
                bus.PCSource      = 2'b01;
            end
            S_JUMP: begin
                bus.pc_write = 1'b1;
                bus.PCSource = 2'b10;
            end
            S_ILLEGAL: begin
                bus.illegal_op = 1'b1;
            end
            default: begin
                w_next_state = S_FETCH;
            end
        endcase

        // Reset masks every enable and select regardless of the held state.
        if (reset) begin
            bus.ALUOp         = 2'b00;
            bus.ALUSrcA       = 1'b0;
            bus.ALUSrcB       = 2'b00;
            bus.IorD          = 1'b0;
            bus.mem_read      = 1'b0;
            bus.mem_write     = 1'b0;
            bus.ir_write      = 1'b0;
            bus.reg_write     = 1'b0;
            bus.RegDst        = 1'b0;
            bus.MemtoReg      = 1'b0;
            bus.pc_write      = 1'b0;
            bus.pc_write_cond = 1'b0;
            bus.PCSource      = 2'b00;
            bus.illegal_op    = 1'b0;
        end
    end

    assign bus.state = r_state;

endmodule
`default_nettype wire

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multicycle MIPS datapath. It sits directly upstream of the ALU-control decoder and drives its 2-bit `ALUOp`. It also sequences every datapath enable and mux select across the fetch, decode, execute, memory and writeback steps. It adds a memory wait handshake and flags illegal opcodes.

## Interface
Parameters:
- `OP_RTYPE`, default 6'b000000, R-type opcode.
- `OP_LW`, default 6'b100011, load word.
- `OP_SW`, default 6'b101011, store word.
- `OP_BEQ`, default 6'b000100, branch-if-equal.
- `OP_J`, default 6'b000010, jump.

Ports:
- `clk`  in  1  Single clock. All state changes on the rising edge.
- `reset`  in  1  Synchronous, active-high.
- `opcode`  in  6  `IR[31:26]`. Sampled only in DECODE.
- `mem_ready`  in  1  Memory has completed the current access this cycle.
- `ALUOp`  out  2  To the ALU-control decoder: 00 = add, 01 = sub, 10 = use funct.
- `ALUSrcA`  out  1  0 = PC, 1 = register A.
- `ALUSrcB`  out  2  00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `IorD`  out  1  Memory address source: 0 = PC, 1 = ALUOut.
- `mem_read`, `mem_write`, `ir_write`, `reg_write`  out  1 each  Enables.
- `RegDst`  out  1  Destination register: 0 = rt, 1 = rd.
- `MemtoReg`  out  1  Writeback data: 0 = ALUOut, 1 = MDR.
- `pc_write`, `pc_write_cond`  out  1 each  PC update enables.
- `PCSource`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- `illegal_op`  out  1  One-cycle pulse when an unrecognised opcode is decoded.
- `state`  out  4  Current state encoding, for debug.

## Operation
States and encodings: FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5, EXEC = 6, RCOMP = 7, BRANCH = 8, JUMP = 9, ILLEGAL = 10. Codes 11–15 are unreachable and go to FETCH.

Moore outputs; any output not listed for a state is 0:
- FETCH: `mem_read` = 1, `ALUSrcB` = 01, `ALUOp` = 00. `ir_write` and `pc_write` are both asserted only when `mem_ready` = 1.
- DECODE: `ALUSrcB` = 11, `ALUOp` = 00. Computes the branch target.
- MEMADR: `ALUSrcA` = 1, `ALUSrcB` = 10, `ALUOp` = 00.
- MEMRD: `mem_read` = 1, `IorD` = 1.
- MEMWB: `reg_write` = 1, `MemtoReg` = 1, `RegDst` = 0.
- MEMWR: `mem_write` = 1, `IorD` = 1. `mem_write` stays asserted until `mem_ready` = 1.
- EXEC: `ALUSrcA` = 1, `ALUSrcB` = 00, `ALUOp` = 10.
- RCOMP: `reg_write` = 1, `RegDst` = 1, `MemtoReg` = 0.
- BRANCH: `ALUSrcA` = 1, `ALUSrcB` = 00, `ALUOp` = 01, `pc_write_cond` = 1, `PCSource` = 01.
- JUMP: `pc_write` = 1, `PCSource` = 10.
- ILLEGAL: `illegal_op` = 1. No enables are asserted.

Transitions:
- FETCH → DECODE when `mem_ready` = 1; otherwise stay in FETCH.
- DECODE:
  - `OP_LW` or `OP_SW` → MEMADR.
  - `OP_RTYPE` → EXEC.
  - `OP_BEQ` → BRANCH.
  - `OP_J` → JUMP.
  - Any other opcode → ILLEGAL.
- MEMADR → MEMRD if the opcode captured in DECODE was LW; → MEMWR if it was SW. A 1-bit `is_load` flag is registered in DECODE for this purpose.
- MEMRD → MEMWB when `mem_ready` = 1; otherwise stay.
- MEMWR → FETCH when `mem_ready` = 1; otherwise stay.
- MEMWB, RCOMP, BRANCH, JUMP and ILLEGAL → FETCH unconditionally.
- EXEC → RCOMP.

Reset behaviour:
- A reset asserted in any state, including during a memory wait, forces `state` = FETCH on the next edge and clears `is_load`.
- While `reset` is high, all enables are forced to 0: `mem_read`, `mem_write`, `ir_write`, `reg_write`, `pc_write`, `pc_write_cond`, `illegal_op`.
- While `reset` is high, all selects are forced to 0: `ALUOp`, `ALUSrcA`, `ALUSrcB`, `IorD`, `RegDst`, `MemtoReg`, `PCSource`.

## Timing
- Outputs are combinational from the registered state and `mem_ready` only. There is no path from `opcode` to any output.
- Instruction latency with `mem_ready` held at 1:
  - LW = 5 cycles.
  - SW = 4 cycles.
  - R-type = 4 cycles.
  - BEQ = 3 cycles.
  - J = 3 cycles.
  - Illegal opcode = 3 cycles.
- Each cycle with `mem_ready` = 0 in FETCH, MEMRD or MEMWR adds one cycle. All outputs hold steady during the wait.
- `ir_write` and `pc_write` in FETCH assert in exactly one cycle per fetch: the cycle in which `mem_ready` = 1.
- `illegal_op` is high for exactly one cycle per illegal decode.
- First cycle after `reset` deasserts: `state` = FETCH and `mem_read` = 1.

## Test plan
- **R-type sequence.** Reset, then `opcode` = 000000 with `mem_ready` = 1. `state` must go 0, 1, 6, 7, 0. `ALUOp` = 10 in EXEC. `reg_write` = 1 and `RegDst` = 1 in RCOMP only.
- **LW with wait.** `opcode` = 100011, with `mem_ready` = 0 for 2 cycles in MEMRD. Sequence must be 0, 1, 2, 3, 3, 3, 4, 0. `IorD` = 1 throughout MEMRD. `reg_write` must pulse once, with `MemtoReg` = 1.
- **SW.** `opcode` = 101011 with `mem_ready` = 1. Sequence must be 0, 1, 2, 5, 0. `mem_write` = 1 for exactly 1 cycle. `reg_write` must never assert.
- **BEQ then J.** BEQ must give sequence 0, 1, 8, 0, with `ALUOp` = 01, `pc_write_cond` = 1 and `PCSource` = 01 in BRANCH. J must give 0, 1, 9, 0, with `pc_write` = 1 and `PCSource` = 10 in JUMP.
- **Illegal opcode.** `opcode` = 111111. Sequence must be 0, 1, 10, 0. `illegal_op` pulses for 1 cycle, and no write enable asserts.
- **Reset mid-stall.** Assert `reset` while in MEMWR with `mem_ready` = 0. On the next cycle `state` = 0, and all enables stay 0 while `reset` remains high.
